// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit for the Hi/Lo register pair.
// Multiply uses shift-add on operand magnitudes. Divide uses restoring
// division, one quotient bit per cycle. A FIX cycle applies the sign
// correction, and DONE presents the result for a single cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] RegA,
  input  logic [WIDTH-1:0] RegB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             divide_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_hi;   // multiply: upper partial product; divide: remainder
  logic [WIDTH-1:0]   acc_lo;   // multiply: multiplier/lower product; divide: dividend/quotient
  logic [WIDTH-1:0]   opnd;     // multiply: multiplicand magnitude; divide: divisor magnitude
  logic               neg_res;  // operand signs differ (signed ops only)
  logic               neg_rem;  // dividend was negative (signed ops only)

  // Operand decode at acceptance time. op[0]=1 selects the unsigned variants,
  // and op[1]=1 selects divide.
  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_neg    = ~op[0] & RegA[WIDTH-1];
  assign b_neg    = ~op[0] & RegB[WIDTH-1];
  assign a_mag    = a_neg ? (~RegA + 1'b1) : RegA;
  assign b_mag    = b_neg ? (~RegB + 1'b1) : RegB;
  assign div_zero = op[1] & (RegB == '0);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of block ordering.
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives state_d,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = div_zero ? DONE : RUN;
      RUN:  if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One multiply or divide step, derived from the current accumulators.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opnd});
    // The trial is always below twice the divisor, so the difference fits in
    // WIDTH bits whenever it is used.
    div_diff  = div_trial[WIDTH-1:0] - opnd;
  end

  // Sign correction applied on the FIX -> DONE edge.
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    prod_neg = -{acc_hi, acc_lo};
    if (!op_q[0]) begin
      if (op_q[1]) begin
        if (neg_res) fix_lo = -acc_lo;
        if (neg_rem) fix_hi = -acc_hi;
      end else if (neg_res) begin
        {fix_hi, fix_lo} = prod_neg;
      end
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: every datapath register is cleared on reset, so an aborted
      // operation leaves no residue and Hi/Lo read zero afterwards.
      op_q           <= '0;
      cnt_q          <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      opnd           <= '0;
      neg_res        <= 1'b0;
      neg_rem        <= 1'b0;
      Hi             <= '0;
      Lo             <= '0;
      divide_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q           <= op;
            cnt_q          <= CNT_W'(WIDTH);
            divide_by_zero <= div_zero;
            neg_res        <= a_neg ^ b_neg;
            neg_rem        <= a_neg;
            acc_hi         <= '0;
            if (op[1]) begin
              opnd   <= b_mag;
              acc_lo <= a_mag;
            end else begin
              opnd   <= a_mag;
              acc_lo <= b_mag;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (op_q[1]) begin
            acc_hi <= div_ge ? div_diff : div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          Hi <= fix_hi;
          Lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8. The stimulus
// pushes expected results, and per-instance monitors pop and compare them on done.
module tb_mult_div_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dbz;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        q32[$];
  exp_t        q8[$];
  int          bcnt32 = 0;
  int          bcnt8 = 0;

  logic        start32 = 1'b0, start8 = 1'b0;
  logic [1:0]  op32 = '0, op8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, dbz32, busy8, done8, dbz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .Clk(clk), .Reset(rst), .start(start32), .op(op32), .RegA(a32), .RegB(b32),
    .busy(busy32), .done(done32), .Hi(hi32), .Lo(lo32), .divide_by_zero(dbz32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .start(start8), .op(op8), .RegA(a8), .RegB(b8),
    .busy(busy8), .done(done8), .Hi(hi8), .Lo(lo8), .divide_by_zero(dbz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst || !busy32) bcnt32 <= 0;
    else                bcnt32 <= bcnt32 + 1;
    if (done32) begin
      if (q32.size() == 0) begin
        check("spurious done32", 64'(done32), 64'd0);
      end else begin
        e = q32.pop_front();
        check({e.name, " Hi"}, 64'(hi32), e.hi);
        check({e.name, " Lo"}, 64'(lo32), e.lo);
        check({e.name, " dbz"}, 64'(dbz32), 64'(e.dbz));
        check({e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
        check({e.name, " busy cycles"}, 64'(bcnt32 + 1), 64'(e.lat));
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst || !busy8) bcnt8 <= 0;
    else               bcnt8 <= bcnt8 + 1;
    if (done8) begin
      if (q8.size() == 0) begin
        check("spurious done8", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        check({e.name, " Hi"}, 64'(hi8), e.hi);
        check({e.name, " Lo"}, 64'(lo8), e.lo);
        check({e.name, " dbz"}, 64'(dbz8), 64'(e.dbz));
        check({e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
        check({e.name, " busy cycles"}, 64'(bcnt8 + 1), 64'(e.lat));
      end
    end
  end

  // Waits for the selected instance to go idle, issues one op, and pushes its expectation.
  task automatic issue(input int w, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] ehi,
                       input logic [63:0] elo, input logic edbz, input string name);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while ((w == 32 ? busy32 : busy8) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check({name, " idle wait"}, 64'(w == 32 ? busy32 : busy8), 64'd0);
    if (w == 32) begin
      start32 = 1'b1; op32 = o; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end
    @(posedge clk);
    #1;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.name = name; e.acc = cyc;
    e.lat = edbz ? 1 : w + 2;
    if (w == 32) begin
      q32.push_back(e);
      start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    end else begin
      q8.push_back(e);
      start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    end
  endtask

  task automatic wait_idle32();
    int guard = 0;
    @(negedge clk);
    while (busy32 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("wait idle32", 64'(busy32), 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset Hi", 64'(hi32), 64'd0);
    check("reset Lo", 64'(lo32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    check("reset dbz", 64'(dbz32), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply and divide vectors at WIDTH=32; consecutive ops run back-to-back.
    issue(32, MULT,  64'd7,          64'hFFFFFFFD, 64'hFFFFFFFF, 64'hFFFFFFEB, 1'b0, "mult 7*-3");
    issue(32, MULTU, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFE, 64'h00000001, 1'b0, "multu max*max");
    issue(32, MULT,  64'hFFFFFFFF,   64'hFFFFFFFF, 64'h0,        64'h1,        1'b0, "mult -1*-1");
    issue(32, DIV,   64'hFFFFFFF9,   64'd2,        64'hFFFFFFFF, 64'hFFFFFFFD, 1'b0, "div -7/2");
    issue(32, DIV,   64'd7,          64'hFFFFFFFE, 64'h1,        64'hFFFFFFFD, 1'b0, "div 7/-2");
    issue(32, DIV,   64'h80000000,   64'hFFFFFFFF, 64'h0,        64'h80000000, 1'b0, "div minneg/-1");
    issue(32, DIVU,  64'd100,        64'd7,        64'd2,        64'd14,       1'b0, "divu 100/7");

    // Divide by zero keeps Hi/Lo and sets the sticky flag.
    issue(32, DIVU,  64'd55,         64'd0,        64'd2,        64'd14,       1'b1, "divu by zero");
    repeat (3) @(negedge clk);
    check("dbz sticky", 64'(dbz32), 64'd1);
    check("dbz idle busy", 64'(busy32), 64'd0);

    // The next accepted start clears the flag. A start pulse during busy is ignored.
    issue(32, MULTU, 64'h12345678,   64'h10,       64'h1,        64'h23456780, 1'b0, "multu after dbz");
    check("dbz cleared", 64'(dbz32), 64'd0);
    repeat (5) @(negedge clk);
    start32 = 1'b1; op32 = DIVU; a32 = 32'd99; b32 = 32'd0;
    @(negedge clk);
    start32 = 1'b0;
    issue(32, MULT,  64'hFFFFFFFF,   64'hFFFFFFFF, 64'h0,        64'h1,        1'b0, "mult back-to-back");

    // Reset around iteration 10 aborts the op. No done follows.
    wait_idle32();
    start32 = 1'b1; op32 = MULT; a32 = 32'd1234; b32 = 32'd5678;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort Hi", 64'(hi32), 64'd0);
    check("abort Lo", 64'(lo32), 64'd0);
    check("abort busy", 64'(busy32), 64'd0);
    check("abort done", 64'(done32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32, MULT,  64'h00010000,   64'h00010000, 64'h1,        64'h0,        1'b0, "mult after abort");

    // The same cases at WIDTH=8, with a latency of 10.
    issue(8, MULT,  64'd7,   64'hFD, 64'hFF, 64'hEB, 1'b0, "w8 mult 7*-3");
    issue(8, MULTU, 64'hFF,  64'hFF, 64'hFE, 64'h01, 1'b0, "w8 multu max*max");
    issue(8, DIV,   64'hF9,  64'd2,  64'hFF, 64'hFD, 1'b0, "w8 div -7/2");
    issue(8, DIVU,  64'd100, 64'd7,  64'd2,  64'd14, 1'b0, "w8 divu 100/7");
    issue(8, DIV,   64'h80,  64'hFF, 64'h0,  64'h80, 1'b0, "w8 div minneg/-1");
    issue(8, DIVU,  64'd9,   64'd0,  64'd0,  64'h80, 1'b1, "w8 divu by zero");

    // Drain the scoreboards.
    for (int i = 0; i < 200 && (q32.size() + q8.size()) > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard drained", 64'(q32.size() + q8.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
